// File: rtl/apb_pkg.sv
// Shared FSM state type and constants for the APB slave bank.
package apb_pkg;

  typedef enum logic {StIdle, StAccess} apb_state_e;

  localparam int unsigned ByteOff = 2;
  localparam int unsigned CntW    = 4;

endpackage

// File: rtl/apb_slave_regbank.sv
// Storage for one APB slave: DEPTH words, single write port, asynchronous read port.
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       DEPTH      = 16,
  parameter logic [DATA_W-1:0] RESET_DATA = DATA_W'(25),
  parameter int unsigned       IDX_W      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_DATA;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_bank.sv
// APB bank of NSLV memory slaves with WAIT_CYC wait states per access.
// Define APB_SLVERR_EN to report out-of-range and multi-select transfers on pslverr.
module apb_slave_bank
  import apb_pkg::*;
#(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       NSLV       = 3,
  parameter int unsigned       DEPTH      = 16,
  parameter int unsigned       WAIT_CYC   = 1,
  parameter logic [DATA_W-1:0] RESET_DATA = DATA_W'(25)
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic [NSLV-1:0]   psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned SEL_W = (NSLV > 1) ? $clog2(NSLV) : 1;

  apb_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [NSLV-1:0]   psel_q;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic              capture;
  logic              complete;
  logic              oor;
  logic              err;
  logic [SEL_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  word_idx;
  logic [NSLV-1:0]   bank_we;
  logic [DATA_W-1:0] bank_rdata [NSLV];

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      psel_q  <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        psel_q  <= psel;
        addr_q  <= paddr;
        write_q <= pwrite;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (psel != '0 && !penable) begin
          state_d = StAccess;
          cnt_d   = CntW'(WAIT_CYC);
          capture = 1'b1;
        end
      end
      StAccess: begin
        // Any deviation from the captured select, or a dropped enable, abandons the transfer.
        if (!penable || psel != psel_q) begin
          state_d = StIdle;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          complete = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Lowest set bit wins when more than one select is active.
  always_comb begin
    sel_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (psel_q[i]) begin
        sel_idx = SEL_W'(i);
      end
    end
  end

  assign word_idx = addr_q[ByteOff +: IDX_W];
  assign oor      = (addr_q >> (ByteOff + IDX_W)) != '0;

`ifdef APB_SLVERR_EN
  logic multi;
  assign multi   = (psel_q & (psel_q - 1'b1)) != '0;
  assign err     = oor | multi;
  assign pslverr = complete & err;
`else
  assign err     = oor;
  assign pslverr = 1'b0;
`endif

  assign pready = complete;
  assign prdata = (complete && !write_q && !err) ? bank_rdata[sel_idx] : '0;

  for (genvar g = 0; g < NSLV; g++) begin : g_bank
    assign bank_we[g] = complete & write_q & ~err & (sel_idx == SEL_W'(g));

    apb_slave_regbank #(
      .DATA_W     (DATA_W),
      .DEPTH      (DEPTH),
      .RESET_DATA (RESET_DATA),
      .IDX_W      (IDX_W)
    ) u_regbank (
      .clk   (hclk),
      .rst   (hreset),
      .we    (bank_we[g]),
      .waddr (word_idx),
      .wdata (pwdata),
      .raddr (word_idx),
      .rdata (bank_rdata[g])
    );
  end

endmodule

// File: tb/tb_apb_slave_bank.sv
// Self-checking bench: one WAIT_CYC=1 and one WAIT_CYC=0 instance against a memory-array model.
module tb_apb_slave_bank;

  logic        clk = 1'b0;
  logic        hreset;
  logic [2:0]  psel_a, psel_b;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [2][3][16];

  always #5 clk = ~clk;

  apb_slave_bank #(
    .DATA_W(32), .ADDR_W(32), .NSLV(3), .DEPTH(16), .WAIT_CYC(1), .RESET_DATA(32'd25)
  ) u_dut (
    .hclk(clk), .hreset(hreset), .psel(psel_a), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a)
  );

  apb_slave_bank #(
    .DATA_W(32), .ADDR_W(32), .NSLV(3), .DEPTH(16), .WAIT_CYC(0), .RESET_DATA(32'd25)
  ) u_dut_w0 (
    .hclk(clk), .hreset(hreset), .psel(psel_b), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b)
  );

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 3; s++)
        for (int w = 0; w < 16; w++)
          mem[d][s][w] = 32'd25;
  endtask

  task automatic go_idle();
    @(negedge clk);
    psel_a  = '0;
    psel_b  = '0;
    penable = 1'b0;
  endtask

  // One complete transfer on instance d (0: WAIT_CYC=1, 1: WAIT_CYC=0), checked cycle by cycle.
  task automatic xfer(input int d, input logic [2:0] sel, input logic [31:0] addr,
                      input logic wr, input logic [31:0] wdata, input string name);
    int          waits;
    int          idx;
    logic        oor, multi, err, exp_err;
    logic [31:0] exp_rd;
    logic        rdy, serr;
    logic [31:0] rd;
    waits = (d == 0) ? 1 : 0;
    oor   = (addr >> 6) != 0;
    multi = (sel & (sel - 3'd1)) != 0;
    idx   = sel[0] ? 0 : (sel[1] ? 1 : 2);
`ifdef APB_SLVERR_EN
    err     = oor | multi;
    exp_err = err;
`else
    err     = oor;
    exp_err = 1'b0;
`endif
    exp_rd = (!wr && !err) ? mem[d][idx][addr[5:2]] : 32'd0;

    @(negedge clk);
    psel_a  = (d == 0) ? sel : 3'b000;
    psel_b  = (d == 1) ? sel : 3'b000;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    @(negedge clk);
    penable = 1'b1;
    for (int k = 0; k <= waits; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      rdy = (d == 0) ? pready_a : pready_b;
      checks++;
      if (rdy !== (k == waits)) begin
        errors++;
        $display("FAIL %s pready access cycle %0d: got %b want %b", name, k, rdy, k == waits);
      end
    end
    serr = (d == 0) ? pslverr_a : pslverr_b;
    rd   = (d == 0) ? prdata_a : prdata_b;
    checks++;
    if (serr !== exp_err) begin
      errors++;
      $display("FAIL %s pslverr: got %b want %b", name, serr, exp_err);
    end
    checks++;
    if (rd !== exp_rd) begin
      errors++;
      $display("FAIL %s prdata: got %h want %h", name, rd, exp_rd);
    end
    if (wr && !err) mem[d][idx][addr[5:2]] = wdata;
  endtask

  task automatic test_reset();
    hreset  = 1'b1;
    psel_a  = '0;
    psel_b  = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({pready_a, pslverr_a, prdata_a, pready_b, pslverr_b, prdata_b} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got %b%b%h %b%b%h want all zero",
               pready_a, pslverr_a, prdata_a, pready_b, pslverr_b, prdata_b);
    end
    hreset = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    xfer(0, 3'b001, 32'h08, 1'b0, 32'h0, "read_reset_value");
    go_idle();
    xfer(0, 3'b010, 32'h0C, 1'b1, 32'hDEADBEEF, "write_s1");
    go_idle();
    xfer(0, 3'b010, 32'h0C, 1'b0, 32'h0, "readback_s1");
    go_idle();
    xfer(0, 3'b001, 32'h0C, 1'b0, 32'h0, "read_s0_untouched");
    go_idle();
  endtask

  task automatic test_back_to_back();
    xfer(1, 3'b001, 32'h04, 1'b1, 32'hA5A5A5A5, "b2b_write");
    xfer(1, 3'b001, 32'h04, 1'b0, 32'h0, "b2b_read");
    xfer(0, 3'b100, 32'h3C, 1'b1, 32'h13579BDF, "b2b_w1_write");
    xfer(0, 3'b100, 32'h3C, 1'b0, 32'h0, "b2b_w1_read");
    go_idle();
  endtask

  task automatic test_errors();
    xfer(0, 3'b010, 32'h40, 1'b1, 32'h1234, "oor_write");
    go_idle();
    xfer(0, 3'b010, 32'h00, 1'b0, 32'h0, "oor_alias_unchanged");
    go_idle();
    xfer(0, 3'b010, 32'h40, 1'b0, 32'h0, "oor_read");
    go_idle();
    xfer(0, 3'b011, 32'h10, 1'b1, 32'h5555, "multi_write");
    go_idle();
    xfer(0, 3'b001, 32'h10, 1'b0, 32'h0, "multi_effect_s0");
    go_idle();
    xfer(0, 3'b010, 32'h10, 1'b0, 32'h0, "multi_effect_s1");
    go_idle();
  endtask

  task automatic test_abort();
    @(negedge clk);
    psel_a  = 3'b010;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h0C;
    pwdata  = 32'h0BAD0BAD;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    penable = 1'b0;
    #1;
    checks++;
    if (pready_a !== 1'b0) begin
      errors++;
      $display("FAIL abort pready: got %b want 0", pready_a);
    end
    @(negedge clk);
    psel_a = 3'b000;
    // Enable without a setup phase must be ignored by an idle slave.
    @(negedge clk);
    psel_a  = 3'b010;
    penable = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (pready_a !== 1'b0) begin
      errors++;
      $display("FAIL abort idle_ignores_enable: got %b want 0", pready_a);
    end
    go_idle();
    xfer(0, 3'b010, 32'h0C, 1'b0, 32'h0, "abort_no_write");
    go_idle();
    // Select change during the wait cycle also abandons.
    @(negedge clk);
    psel_a  = 3'b001;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h14;
    pwdata  = 32'hCAFEF00D;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel_a = 3'b100;
    #1;
    checks++;
    if (pready_a !== 1'b0) begin
      errors++;
      $display("FAIL abort psel_change pready: got %b want 0", pready_a);
    end
    go_idle();
    xfer(0, 3'b001, 32'h14, 1'b0, 32'h0, "psel_abort_no_write");
    xfer(0, 3'b100, 32'h14, 1'b0, 32'h0, "psel_abort_no_write_s2");
    go_idle();
  endtask

  task automatic test_reset_in_access();
    @(negedge clk);
    psel_a  = 3'b001;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h00;
    pwdata  = 32'hFFFF0000;
    @(negedge clk);
    penable = 1'b1;
    hreset  = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({pready_a, pslverr_a, prdata_a} !== '0) begin
      errors++;
      $display("FAIL reset_in_access outputs: got %b %b %h want 0 0 0",
               pready_a, pslverr_a, prdata_a);
    end
    hreset = 1'b0;
    model_reset();
    go_idle();
    xfer(0, 3'b001, 32'h00, 1'b0, 32'h0, "reset_in_access_read");
    go_idle();
  endtask

  task automatic test_random();
    int          d;
    logic [2:0]  sel;
    logic [31:0] addr;
    logic        wr;
    for (int i = 0; i < 80; i++) begin
      d = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) begin
        sel = 3'($urandom_range(3, 7));
        if (sel == 3'b100) sel = 3'b101;
      end else begin
        sel = 3'b001 << $urandom_range(0, 2);
      end
      if ($urandom_range(0, 9) == 0) addr = $urandom | 32'h40;
      else addr = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      wr = 1'($urandom_range(0, 1));
      xfer(d, sel, addr, wr, $urandom, "random");
      if ($urandom_range(0, 1) == 1) go_idle();
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_errors();
    test_abort();
    test_reset_in_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
